// File: rtl/l2_refill_responder_if.sv
// Bus bundle between the per-thread L1 refill requesters, the L2 refill
// responder and the backing memory.
//   master : responder view (takes L1 requests and memory responses; drives the
//            memory request, the shared L2 response bus and busy)
//   slave  : environment view (L1 buffers + memory), directions mirrored
// Signals:
//   br_req / req_refill / req_spec  per-thread level requests
//   req_addr                        per-thread fetch address, thread i at [i*WIDTH +: WIDTH]
//   mem_req / mem_addr / mem_ready  memory read request handshake
//   mem_rsp_valid / mem_rsp_line    memory read data (1-cycle pulse)
//   l2addr / l2_tid / l2_line / l2_valid_rsp  shared broadcast response bus
//   busy                            responder not idle
interface l2_refill_responder_if #(
   parameter int unsigned NTHREADS   = 4,
   parameter int unsigned TID_BITS   = 2,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned LINE_WORDS = 4
);
   logic [NTHREADS-1:0]         br_req;
   logic [NTHREADS-1:0]         req_refill;
   logic [NTHREADS-1:0]         req_spec;
   logic [NTHREADS*WIDTH-1:0]   req_addr;
   logic                        mem_req;
   logic [WIDTH-1:0]            mem_addr;
   logic                        mem_ready;
   logic                        mem_rsp_valid;
   logic [LINE_WORDS*WIDTH-1:0] mem_rsp_line;
   logic [WIDTH-1:0]            l2addr;
   logic [TID_BITS-1:0]         l2_tid;
   logic [LINE_WORDS*WIDTH-1:0] l2_line;
   logic                        l2_valid_rsp;
   logic                        busy;

   modport master (
      input  br_req, req_refill, req_spec, req_addr, mem_ready, mem_rsp_valid, mem_rsp_line,
      output mem_req, mem_addr, l2addr, l2_tid, l2_line, l2_valid_rsp, busy
   );

   modport slave (
      output br_req, req_refill, req_spec, req_addr, mem_ready, mem_rsp_valid, mem_rsp_line,
      input  mem_req, mem_addr, l2addr, l2_tid, l2_line, l2_valid_rsp, busy
   );
endinterface

// File: rtl/l2_refill_responder.sv
// L2 refill responder: arbitrates round-robin among per-thread branch, refill
// and next-line speculative requests, issues one line read at a time to memory
// and broadcasts the returned line with its aligned address and thread ID.
// Ports:
//   clock  clock
//   reset  synchronous, active-high reset
//   bus    l2_refill_responder_if.master (L1 requests, memory handshake, L2 response bus)
module l2_refill_responder #(
   parameter int unsigned NTHREADS   = 4,
   parameter int unsigned TID_BITS   = 2,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   l2_refill_responder_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                      state_q, state_d;
   logic [TID_BITS-1:0]         ptr_q, ptr_d;
   logic [TID_BITS-1:0]         tid_q, tid_d;
   logic [WIDTH-1:0]            tgt_q, tgt_d;
   logic                        spec_q, spec_d;
   logic [NTHREADS-1:0]         ls_valid_q, ls_valid_d;
   logic [WIDTH-1:0]            ls_addr_q [NTHREADS];
   logic [WIDTH-1:0]            ls_addr_d [NTHREADS];

   logic                        mem_req_q, mem_req_d;
   logic [WIDTH-1:0]            mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]            l2addr_q, l2addr_d;
   logic [TID_BITS-1:0]         l2_tid_q, l2_tid_d;
   logic [LINE_WORDS*WIDTH-1:0] l2_line_q, l2_line_d;
   logic                        l2_valid_q, l2_valid_d;
   logic                        busy_q, busy_d;

   // Per-thread effective request after priority and spec suppression
   logic [NTHREADS-1:0]         elig;
   logic [NTHREADS-1:0]         is_spec;
   logic [WIDTH-1:0]            cand [NTHREADS];

   always_comb begin
      logic [WIDTH-1:0] base;
      base = '0;
      for (int i = 0; i < NTHREADS; i++) begin
         base = bus.req_addr[i*WIDTH +: WIDTH] & ~WIDTH'(15);
         if (bus.br_req[i] || bus.req_refill[i]) begin
            elig[i]    = 1'b1;
            is_spec[i] = 1'b0;
            cand[i]    = base;
         end else if (bus.req_spec[i]) begin
            // Next line wraps naturally at 2^WIDTH
            cand[i]    = base + WIDTH'(16);
            is_spec[i] = 1'b1;
            // Don't refetch the line we already prefetched for this thread
            elig[i]    = !(ls_valid_q[i] && (ls_addr_q[i] == cand[i]));
         end else begin
            elig[i]    = 1'b0;
            is_spec[i] = 1'b0;
            cand[i]    = base;
         end
      end
   end

   // Round-robin pick: first eligible thread at or after the pointer
   logic                found;
   logic [TID_BITS-1:0] win;

   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NTHREADS; k++) begin
         idx = (int'(ptr_q) + k) % NTHREADS;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = TID_BITS'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tid_d      = tid_q;
      tgt_d      = tgt_q;
      spec_d     = spec_q;
      ls_valid_d = ls_valid_q;
      ls_addr_d  = ls_addr_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      l2addr_d   = l2addr_q;
      l2_tid_d   = l2_tid_q;
      l2_line_d  = l2_line_q;
      l2_valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               tid_d      = win;
               tgt_d      = cand[win];
               spec_d     = is_spec[win];
               ptr_d      = (win == TID_BITS'(NTHREADS - 1)) ? '0 : win + TID_BITS'(1);
               mem_req_d  = 1'b1;
               mem_addr_d = cand[win];
               state_d    = StIssue;
            end
         end
         StIssue: begin
            if (bus.mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = StWait;
            end
         end
         StWait: begin
            if (bus.mem_rsp_valid) begin
               l2_line_d  = bus.mem_rsp_line;
               l2addr_d   = tgt_q;
               l2_tid_d   = tid_q;
               l2_valid_d = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            // A demand fetch invalidates any remembered prefetch for the thread
            ls_valid_d[tid_q] = spec_q;
            if (spec_q) begin
               ls_addr_d[tid_q] = tgt_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         tid_q      <= '0;
         tgt_q      <= '0;
         spec_q     <= 1'b0;
         ls_valid_q <= '0;
         for (int i = 0; i < NTHREADS; i++) begin
            ls_addr_q[i] <= '0;
         end
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         l2addr_q   <= '0;
         l2_tid_q   <= '0;
         l2_line_q  <= '0;
         l2_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tid_q      <= tid_d;
         tgt_q      <= tgt_d;
         spec_q     <= spec_d;
         ls_valid_q <= ls_valid_d;
         for (int i = 0; i < NTHREADS; i++) begin
            ls_addr_q[i] <= ls_addr_d[i];
         end
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         l2addr_q   <= l2addr_d;
         l2_tid_q   <= l2_tid_d;
         l2_line_q  <= l2_line_d;
         l2_valid_q <= l2_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.mem_req      = mem_req_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.l2addr       = l2addr_q;
   assign bus.l2_tid       = l2_tid_q;
   assign bus.l2_line      = l2_line_q;
   assign bus.l2_valid_rsp = l2_valid_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_l2_refill_responder.sv
// Directed self-checking bench for l2_refill_responder.
module tb_l2_refill_responder;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   l2_refill_responder_if #(
      .NTHREADS(4), .TID_BITS(2), .WIDTH(32), .LINE_WORDS(4)
   ) bus ();

   l2_refill_responder #(
      .NTHREADS(4), .TID_BITS(2), .WIDTH(32), .LINE_WORDS(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " mem_req"},  128'(bus.mem_req), 128'(0));
      check({tag, " mem_addr"}, 128'(bus.mem_addr), 128'(0));
      check({tag, " busy"},     128'(bus.busy), 128'(0));
      check({tag, " l2addr"},   128'(bus.l2addr), 128'(0));
      check({tag, " l2_tid"},   128'(bus.l2_tid), 128'(0));
      check({tag, " l2_line"},  bus.l2_line, 128'(0));
      check({tag, " l2_valid"}, 128'(bus.l2_valid_rsp), 128'(0));
   endtask

   // Wait (bounded) for a memory request, hold off mem_ready for 'stall' cycles,
   // then accept it, return 'line' and check the broadcast.
   task automatic serve(input string tag, input int tid, input logic [31:0] addr,
                        input logic [127:0] line, input int stall);
      int n;
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " mem_req"},  128'(bus.mem_req), 128'(1));
      check({tag, " mem_addr"}, 128'(bus.mem_addr), 128'(addr));
      for (int s = 0; s < stall; s++) begin
         tick();
         check({tag, " stall mem_req"},  128'(bus.mem_req), 128'(1));
         check({tag, " stall mem_addr"}, 128'(bus.mem_addr), 128'(addr));
      end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      check({tag, " wait mem_req"}, 128'(bus.mem_req), 128'(0));
      check({tag, " wait busy"},    128'(bus.busy), 128'(1));
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_line  = line;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check({tag, " l2_valid"}, 128'(bus.l2_valid_rsp), 128'(1));
      check({tag, " l2addr"},   128'(bus.l2addr), 128'(addr));
      check({tag, " l2_tid"},   128'(bus.l2_tid), 128'(tid));
      check({tag, " l2_line"},  bus.l2_line, line);
      tick();
      check({tag, " pulse end"}, 128'(bus.l2_valid_rsp), 128'(0));
      check({tag, " idle busy"}, 128'(bus.busy), 128'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int cnt;
      bus.br_req        = '0;
      bus.req_refill    = '0;
      bus.req_spec      = '0;
      bus.req_addr      = '0;
      bus.mem_ready     = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_line  = '0;

      // Reset state
      do_reset();
      check_zero_outputs("reset");

      // Single refill, zero-wait memory, cycle-exact
      bus.req_refill = 4'b0100;
      bus.req_addr   = {32'h0, 32'h0000_1238, 32'h0, 32'h0};
      bus.mem_ready  = 1'b1;
      tick();
      bus.req_refill = '0;
      check("single issue mem_req",  128'(bus.mem_req), 128'(1));
      check("single issue mem_addr", 128'(bus.mem_addr), 128'(32'h1230));
      check("single issue busy",     128'(bus.busy), 128'(1));
      tick();
      bus.mem_ready     = 1'b0;
      check("single wait mem_req", 128'(bus.mem_req), 128'(0));
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_line  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("single l2_valid", 128'(bus.l2_valid_rsp), 128'(1));
      check("single l2addr",   128'(bus.l2addr), 128'(32'h1230));
      check("single l2_tid",   128'(bus.l2_tid), 128'(2));
      check("single l2_line",  bus.l2_line, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
      tick();
      check("single pulse end", 128'(bus.l2_valid_rsp), 128'(0));
      check("single busy low",  128'(bus.busy), 128'(0));
      check("single hold addr", 128'(bus.l2addr), 128'(32'h1230));

      // Priority within a thread: branch wins, no +16
      bus.br_req     = 4'b0001;
      bus.req_refill = 4'b0001;
      bus.req_spec   = 4'b0001;
      bus.req_addr   = {32'h0, 32'h0, 32'h0, 32'h0000_400C};
      serve("prio", 0, 32'h4000, 128'h1111, 0);
      bus.br_req     = '0;
      bus.req_refill = '0;
      bus.req_spec   = '0;

      // Round-robin among threads 0, 1, 3
      do_reset();
      bus.req_addr   = {32'h0000_4004, 32'h0000_3004, 32'h0000_2004, 32'h0000_1004};
      bus.req_refill = 4'b1011;
      serve("rr0", 0, 32'h1000, 128'hA0, 0);
      serve("rr1", 1, 32'h2000, 128'hA1, 0);
      serve("rr2", 3, 32'h4000, 128'hA2, 0);
      serve("rr3", 0, 32'h1000, 128'hA3, 0);
      serve("rr4", 1, 32'h2000, 128'hA4, 0);
      bus.req_refill = '0;

      // Spec wrap and suppression on thread 1
      bus.req_addr = {32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0};
      bus.req_spec = 4'b0010;
      serve("spec wrap", 1, 32'h0000_0000, 128'hB0, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.mem_req === 1'b1) cnt++;
      end
      check("spec suppressed", 128'(cnt), 128'(0));
      bus.req_refill = 4'b0010;
      serve("spec refill", 1, 32'hFFFF_FFF0, 128'hB1, 0);
      bus.req_refill = '0;
      serve("spec refetch", 1, 32'h0000_0000, 128'hB2, 0);
      bus.req_spec = '0;

      // Backpressure; requester drops its request while stalled
      bus.req_addr   = {32'hABCD_0127, 32'h0, 32'h0, 32'h0};
      bus.req_refill = 4'b1000;
      tick();
      bus.req_refill = '0;
      serve("bp", 3, 32'hABCD_0120, 128'hC0, 5);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.mem_req === 1'b1) cnt++;
      end
      check("bp single txn", 128'(cnt), 128'(0));

      // Reset while waiting on memory, then a stray response
      bus.req_addr   = {32'h0, 32'h0, 32'h0, 32'h0000_5554};
      bus.req_refill = 4'b0001;
      cnt = 0;
      while (bus.mem_req !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check("rst issue", 128'(bus.mem_req), 128'(1));
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready  = 1'b0;
      bus.req_refill = '0;
      check("rst in wait busy", 128'(bus.busy), 128'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_zero_outputs("post reset");
      tick();
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_line  = 128'hDD;
      tick();
      bus.mem_rsp_valid = 1'b0;
      check("stray l2_valid", 128'(bus.l2_valid_rsp), 128'(0));
      tick();
      check_zero_outputs("stray");
      bus.req_addr   = {32'h0, 32'h0000_7777, 32'h0, 32'h0};
      bus.req_refill = 4'b0100;
      serve("after rst", 2, 32'h7770, 128'hE0, 0);
      bus.req_refill = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l2_refill_responder.md
Name: l2_refill_responder

Overview:
- Responder end of the per-thread L1 instruction-buffer refill protocol.
- Collects branch, refill and speculative (next-line) requests from NTHREADS L1 buffers and arbitrates among them round-robin.
- Issues one line read at a time to the backing memory, then broadcasts the returned line with its aligned address and thread ID on the shared L2 response bus.
- Sits between the per-thread L1 buffers and the L2/memory array.

Parameters:
- NTHREADS, 4, number of hardware threads / L1 buffers.
- TID_BITS, 2, thread-ID width; equals clog2(NTHREADS).
- WIDTH, 32, address and instruction word width.
- LINE_WORDS, 4, words per line; line width is LINE_WORDS*WIDTH = 128.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- br_req  in  NTHREADS  per-thread branch-target request, level.
- req_refill  in  NTHREADS  per-thread demand-miss request, level.
- req_spec  in  NTHREADS  per-thread next-line prefetch request, level.
- req_addr  in  NTHREADS*WIDTH  per-thread fetch address (PC or branch target); thread i uses bits [i*WIDTH +: WIDTH].
- mem_req  out  1  memory read request; held until accepted.
- mem_addr  out  WIDTH  line-aligned memory address; low 4 bits are 0.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rsp_valid  in  1  memory read data valid, 1-cycle pulse.
- mem_rsp_line  in  LINE_WORDS*WIDTH  memory read data.
- l2addr  out  WIDTH  aligned address of the broadcast line.
- l2_tid  out  TID_BITS  thread the broadcast line belongs to.
- l2_line  out  LINE_WORDS*WIDTH  broadcast line data.
- l2_valid_rsp  out  1  response valid, 1-cycle pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - FSM in IDLE; mem_req=0, mem_addr=0, busy=0.
  - l2addr=0, l2_tid=0, l2_line=0, l2_valid_rsp=0.
  - Round-robin pointer = 0.
  - All per-thread last_spec registers invalid.
- Per-thread effective request (priority br_req > req_refill > req_spec):
  - br_req or req_refill: target = req_addr & ~0xF.
  - req_spec: target = (req_addr & ~0xF) + 16, 32-bit wrap (0xFFFFFFF0 -> 0x00000000).
  - A spec request is suppressed when last_spec[i] is valid and equals its target. This prevents repeated prefetch while the L1 sits on word 3.
- Arbitration, in IDLE only:
  - Among threads with an unsuppressed request, pick the first at or after the pointer, wrapping.
  - Latch winner tid and target; pointer <= winner+1 mod NTHREADS.
  - No eligible thread: stay in IDLE, pointer unchanged.
- FSM states and transitions:
  - IDLE -> ISSUE when a winner exists.
  - ISSUE: mem_req=1, mem_addr=latched target. mem_req and mem_addr stay stable until mem_ready=1, then go to WAIT.
  - WAIT: mem_req=0. On mem_rsp_valid, capture l2_line=mem_rsp_line, l2addr=target, l2_tid=winner, then go to RESP.
  - RESP: l2_valid_rsp=1 for exactly this cycle, then go to IDLE.
- Response bus outputs hold their last values between pulses.
- last_spec update:
  - On the RESP cycle, if the served request was spec, last_spec[winner] <= target and valid.
  - If it was branch or refill, last_spec[winner] is invalidated.
- Latency:
  - Request seen in IDLE at cycle T -> mem_req high at T+1.
  - mem_ready at cycle A -> WAIT from A+1.
  - mem_rsp_valid at cycle R -> l2_valid_rsp at R+1 -> IDLE at R+2.
  - Minimum request-to-response time, with zero-wait memory (mem_ready at T+1, mem_rsp_valid at T+2), is 3 cycles.
- Request type is fixed at arbitration. A requester that drops or changes its request after being latched does not abort the transaction; the line is still returned.
- mem_rsp_valid outside WAIT (stray, or from before reset) is ignored.
- mem_ready outside ISSUE is ignored.
- Reset mid-operation in any state: next cycle is IDLE with all reset values; the outstanding memory response is discarded under the stray-response rule above.
- One outstanding memory transaction at a time; no request queueing beyond the level inputs.

Test Plan:
- Single refill: thread 2 req_refill=1, req_addr=0x0000_1238; mem_ready same cycle; mem_rsp_valid 2 cycles later with line L -> mem_addr=0x1230; one l2_valid_rsp pulse with l2addr=0x1230, l2_tid=2, l2_line=L; busy low afterwards.
- Priority within a thread: thread 0 br_req=1, req_refill=1, req_spec=1, addr 0x400C -> served as branch, mem_addr=0x4000, not 0x4010.
- Round-robin: threads 0, 1, 3 hold refill continuously after reset -> grant order 0, 1, 3, 0, 1; thread 2 never granted.
- Spec suppression and wrap: thread 1 req_spec held at addr 0xFFFF_FFFC -> exactly one fetch with mem_addr=0x0000_0000; no second fetch while held; a refill then a spec at the same address refetches 0x0000_0000.
- Backpressure: mem_ready low for 5 cycles -> mem_req and mem_addr stable for all 5; exactly one transaction after mem_ready rises.
- Reset in WAIT, then a stray mem_rsp_valid 2 cycles after reset deasserts -> no l2_valid_rsp; outputs remain 0; a new request is then served normally.
